// File: rtl/cbus_rr_arbiter.sv
// N:1 cbus arbiter: grants one requester a whole transaction, releasing ownership on a ready+last beat.
// Define CBUS_ARB_ROUND_ROBIN_EN for round-robin priority; otherwise the lowest valid index wins.
package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int BEAT_W     = 8,
    localparam int IDX_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  cbus_req_t  [NUM_INPUTS-1:0]  ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0]  iresps,
    output cbus_req_t                    oreq,
    input  cbus_resp_t                   oresp,
    output logic                         busy,
    output logic [IDX_W-1:0]             grant_idx,
    output logic [BEAT_W-1:0]            beat_cnt
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [BEAT_W-1:0]   beat_q, beat_d, beat_inc;
    logic                any_vld;
    logic [IDX_W-1:0]    win;
    logic                owned;
    logic                done;

    // Outputs are gated by reset so the bus goes quiet the moment reset is seen.
    assign owned = (state_q == BUSY) && reset;
    assign done  = oresp.ready && oresp.last;

`ifdef CBUS_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        int idx;
        any_vld = 1'b0;
        win     = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            idx = (int'(ptr_q) + k) % NUM_INPUTS;
            if (!any_vld && ireqs[idx].valid) begin
                any_vld = 1'b1;
                win     = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == BUSY && done)
            ptr_d = grant_q;
    end

    // Pointer parks on the last input so input 0 is searched first after reset.
    always_ff @(posedge clk) begin
        if (!reset) ptr_q <= IDX_W'(NUM_INPUTS - 1);
        else        ptr_q <= ptr_d;
    end
`else
    always_comb begin
        any_vld = 1'b0;
        win     = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (ireqs[i].valid) begin
                any_vld = 1'b1;
                win     = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        beat_d   = beat_q;
        beat_inc = beat_q;
        if (oresp.ready && (beat_q != '1))
            beat_inc = beat_q + 1'b1;
        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (any_vld) begin
                    state_d = BUSY;
                    grant_d = win;
                end
            end
            BUSY: begin
                beat_d = beat_inc;
                if (done) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (owned) begin
            oreq            = ireqs[grant_q];
            iresps[grant_q] = oresp;
        end
    end

    // beat_cnt includes the beat being accepted this cycle.
    assign busy      = owned;
    assign grant_idx = owned ? grant_q : '0;
    assign beat_cnt  = owned ? beat_inc : '0;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed bench for cbus_rr_arbiter: a 2-input instance and a 3-input/2-bit-counter instance.
module tb_cbus_rr_arbiter;
    import cbus_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cbus_req_t  [1:0] ireqs2;
    cbus_resp_t [1:0] iresps2;
    cbus_req_t        oreq2;
    cbus_resp_t       oresp2;
    logic             busy2;
    logic [0:0]       gidx2;
    logic [7:0]       beat2;

    cbus_req_t  [2:0] ireqs3;
    cbus_resp_t [2:0] iresps3;
    cbus_req_t        oreq3;
    cbus_resp_t       oresp3;
    logic             busy3;
    logic [1:0]       gidx3;
    logic [1:0]       beat3;

    cbus_rr_arbiter #(.NUM_INPUTS(2), .BEAT_W(8)) u2 (
        .clk(clk), .reset(reset), .ireqs(ireqs2), .iresps(iresps2), .oreq(oreq2),
        .oresp(oresp2), .busy(busy2), .grant_idx(gidx2), .beat_cnt(beat2)
    );

    cbus_rr_arbiter #(.NUM_INPUTS(3), .BEAT_W(2)) u3 (
        .clk(clk), .reset(reset), .ireqs(ireqs3), .iresps(iresps3), .oreq(oreq3),
        .oresp(oresp3), .busy(busy3), .grant_idx(gidx3), .beat_cnt(beat3)
    );

`ifdef CBUS_ARB_ROUND_ROBIN_EN
    localparam logic [63:0] EXP_G2 = 64'd1;
`else
    localparam logic [63:0] EXP_G2 = 64'd0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] rdy_b  = 6'b110110;   // bit c = ready on BUSY cycle c+1
    int         exp_b [6] = '{0, 1, 2, 2, 3, 4};
    int         exp_f [5] = '{1, 2, 3, 3, 3};

    function automatic cbus_req_t mkreq(input logic [15:0] a);
        cbus_req_t r;
        r       = '0;
        r.valid = 1'b1;
        r.we    = 1'b1;
        r.addr  = a;
        r.wdata = {16'hd000, a};
        return r;
    endfunction

    function automatic cbus_resp_t mkresp(input logic rdy, input logic lst, input logic [31:0] d);
        cbus_resp_t r;
        r.ready = rdy;
        r.last  = lst;
        r.data  = d;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b0;
        ireqs2 = '0;
        oresp2 = '0;
        ireqs3 = '0;
        oresp3 = '0;
        ireqs2[0] = mkreq(16'h0100);
        tick();
        tick();
        chk("rst.busy",   64'(busy2), 64'd0);
        chk("rst.oreq",   64'(oreq2), 64'd0);
        chk("rst.grant",  64'(gidx2), 64'd0);
        chk("rst.beat",   64'(beat2), 64'd0);
        chk("rst.iresps", 64'(iresps2), 64'd0);

        // Two requesters held: alternation with RR, starvation without
        reset = 1'b1;
        ireqs2[1] = mkreq(16'h0200);
        #1;
        chk("A.idle0.busy", 64'(busy2), 64'd0);
        tick();
        chk("A.g1.busy",  64'(busy2), 64'd1);
        chk("A.g1.grant", 64'(gidx2), 64'd0);
        chk("A.g1.oreq",  64'(oreq2), 64'(mkreq(16'h0100)));
        oresp2 = mkresp(1'b1, 1'b1, 32'h0000_00a0);
        #1;
        chk("A.g1.iresp0", 64'(iresps2[0]), 64'(mkresp(1'b1, 1'b1, 32'h0000_00a0)));
        chk("A.g1.iresp1", 64'(iresps2[1]), 64'd0);
        chk("A.g1.beat",   64'(beat2), 64'd1);
        tick();
        oresp2 = '0;
        #1;
        chk("A.gap1.busy",  64'(busy2), 64'd0);
        chk("A.gap1.grant", 64'(gidx2), 64'd0);
        chk("A.gap1.beat",  64'(beat2), 64'd0);
        tick();
        chk("A.g2.busy",  64'(busy2), 64'd1);
        chk("A.g2.grant", 64'(gidx2), EXP_G2);
        oresp2 = mkresp(1'b1, 1'b1, 32'h0000_00a1);
        tick();
        oresp2 = '0;
        #1;
        chk("A.gap2.busy", 64'(busy2), 64'd0);
        tick();
        chk("A.g3.busy",  64'(busy2), 64'd1);
        chk("A.g3.grant", 64'(gidx2), 64'd0);
        oresp2 = mkresp(1'b1, 1'b1, 32'h0000_00a2);
        tick();
        oresp2 = '0;
        ireqs2 = '0;
        #1;
        chk("A.end.busy", 64'(busy2), 64'd0);

        // Reset on beat 2 of a burst aborts ownership and restores input-0 priority
        ireqs2[1] = mkreq(16'h0201);
        tick();
        chk("D.grant", 64'(gidx2), 64'd1);
        oresp2 = mkresp(1'b1, 1'b0, 32'h0000_00d0);
        tick();
        reset = 1'b0;
        #1;
        chk("D.inrst.busy", 64'(busy2), 64'd0);
        chk("D.inrst.oreq", 64'(oreq2), 64'd0);
        tick();
        reset  = 1'b1;
        oresp2 = '0;
        ireqs2[0] = mkreq(16'h0101);
        #1;
        chk("D.post.busy", 64'(busy2), 64'd0);
        chk("D.post.oreq", 64'(oreq2), 64'd0);
        chk("D.post.beat", 64'(beat2), 64'd0);
        tick();
        chk("D.next.busy",  64'(busy2), 64'd1);
        chk("D.next.grant", 64'(gidx2), 64'd0);
        oresp2 = mkresp(1'b1, 1'b1, 32'h0000_00d1);
        tick();
        oresp2 = '0;
        ireqs2 = '0;
        #1;
        chk("D.end.busy", 64'(busy2), 64'd0);

        // 4-beat burst on input 1 with a stall on cycle 4
        ireqs2[1] = mkreq(16'h0210);
        tick();
        chk("B.busy",  64'(busy2), 64'd1);
        chk("B.grant", 64'(gidx2), 64'd1);
        for (int c = 0; c < 6; c++) begin
            oresp2 = mkresp(rdy_b[c], (c == 5), 32'h0000_0b00 + 32'(c));
            #1;
            chk($sformatf("B.c%0d.beat", c + 1), 64'(beat2), 64'(exp_b[c]));
            chk($sformatf("B.c%0d.iresp0", c + 1), 64'(iresps2[0]), 64'd0);
            chk($sformatf("B.c%0d.busy", c + 1), 64'(busy2), 64'd1);
            tick();
        end
        ireqs2 = '0;
        oresp2 = '0;
        #1;
        chk("B.c7.busy", 64'(busy2), 64'd0);
        chk("B.c7.beat", 64'(beat2), 64'd0);

        // Owner drops valid mid-transaction; non-owner request is ignored until IDLE
        ireqs2[0] = mkreq(16'h0120);
        tick();
        chk("E.busy",  64'(busy2), 64'd1);
        chk("E.grant", 64'(gidx2), 64'd0);
        ireqs2[0] = '0;
        ireqs2[1] = mkreq(16'h0220);
        oresp2 = mkresp(1'b1, 1'b0, 32'h0000_00e0);
        #1;
        chk("E.drop.busy",   64'(busy2), 64'd1);
        chk("E.drop.ovalid", 64'(oreq2.valid), 64'd0);
        chk("E.drop.iresp1", 64'(iresps2[1]), 64'd0);
        chk("E.drop.iresp0", 64'(iresps2[0]), 64'(mkresp(1'b1, 1'b0, 32'h0000_00e0)));
        tick();
        oresp2 = '0;
        #1;
        chk("E.hold.busy",  64'(busy2), 64'd1);
        chk("E.hold.grant", 64'(gidx2), 64'd0);
        tick();
        oresp2 = mkresp(1'b1, 1'b1, 32'h0000_00e1);
        #1;
        chk("E.last.busy", 64'(busy2), 64'd1);
        chk("E.last.beat", 64'(beat2), 64'd2);
        tick();
        oresp2 = '0;
        #1;
        chk("E.gap.busy", 64'(busy2), 64'd0);
        tick();
        chk("E.g2.busy",  64'(busy2), 64'd1);
        chk("E.g2.grant", 64'(gidx2), 64'd1);
        chk("E.g2.oreq",  64'(oreq2), 64'(mkreq(16'h0220)));
        oresp2 = mkresp(1'b1, 1'b1, 32'h0000_00e2);
        tick();
        oresp2 = '0;
        ireqs2 = '0;

        // 3 inputs, 2-bit counter: saturation over a 5-beat burst
        ireqs3[2] = mkreq(16'h0300);
        tick();
        chk("F.busy",  64'(busy3), 64'd1);
        chk("F.grant", 64'(gidx3), 64'd2);
        for (int c = 0; c < 5; c++) begin
            oresp3 = mkresp(1'b1, (c == 4), 32'h0000_0f00 + 32'(c));
            #1;
            chk($sformatf("F.b%0d.beat", c + 1), 64'(beat3), 64'(exp_f[c]));
            chk($sformatf("F.b%0d.busy", c + 1), 64'(busy3), 64'd1);
            chk($sformatf("F.b%0d.iresp0", c + 1), 64'(iresps3[0]), 64'd0);
            tick();
        end
        ireqs3 = '0;
        oresp3 = '0;
        #1;
        chk("F.end.busy", 64'(busy3), 64'd0);
        chk("F.end.beat", 64'(beat3), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cbus_rr_arbiter.md
CBUS_RR_ARBITER -- requirements
Module: cbus_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 2, the number of requesting cbus ports; legal range 1..16.
REQ-002 SHALL have parameter BEAT_W, default 8, the width of the per-transaction beat counter.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low; clock clk.
REQ-005 SHALL have port ireqs  input  NUM_INPUTS x cbus_req_t  upstream requests.
REQ-006 SHALL have port iresps  output  NUM_INPUTS x cbus_resp_t  per-requester responses.
REQ-007 SHALL have port oreq  output  cbus_req_t  request to the shared downstream cbus.
REQ-008 SHALL have port oresp  input  cbus_resp_t  downstream response (ready, last, data).
REQ-009 SHALL have port busy  output  1  high while a transaction is owned.
REQ-010 SHALL have port grant_idx  output  $clog2(NUM_INPUTS) (min 1)  index of the current owner; 0 when idle.
REQ-011 SHALL have port beat_cnt  output  BEAT_W  count of ready beats in the current transaction.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-013 In IDLE: oreq = all-zero, all iresps = all-zero, busy = 0, beat_cnt = 0.
REQ-014 In IDLE with at least one ireqs[i].valid: select a winner per REQ-031/032, register it into grant_idx and enter BUSY at the next edge (one-cycle grant latency).
REQ-015 In IDLE with no valid request: remain in IDLE; grant_idx and the priority pointer are unchanged.
REQ-016 In BUSY: oreq = ireqs[grant_idx] passed through combinationally; the requester holds its request stable until it sees last.
REQ-017 In BUSY: iresps[grant_idx] = oresp; every other iresps entry = all-zero.
REQ-018 In BUSY: beat_cnt increments by 1 on each cycle with oresp.ready = 1 and saturates at all-ones.
REQ-019 In BUSY: on oresp.ready = 1 and oresp.last = 1, return to IDLE at the next edge, update the priority pointer to grant_idx, and clear beat_cnt.
REQ-020 SHALL return to IDLE only on REQ-019; an owner dropping valid mid-transaction does not release BUSY.
REQ-021 When last completes while other requests are pending: spend exactly one IDLE cycle, then grant; no back-to-back grant in the same cycle.
REQ-022 Requests arriving in BUSY from non-owners SHALL be ignored until the next IDLE cycle; no response leaks to them.
REQ-023 With NUM_INPUTS = 1: same FSM, grant_idx always 0.
REQ-024 Selection is combinational on the IDLE cycle only; changes to ireqs in BUSY do not affect grant_idx.

Reset
REQ-025 On a clk edge with reset = 0: state <= IDLE, grant_idx <= 0, beat_cnt <= 0, priority pointer <= NUM_INPUTS-1.
REQ-026 Reset asserted mid-transaction SHALL abort ownership immediately; the downstream sees oreq = 0 from the following cycle.
REQ-027 During reset all outputs SHALL take their IDLE values from REQ-013.
REQ-028 After reset is released, input 0 SHALL have highest priority for the first grant.

Configuration
REQ-029 SHALL honour macro CBUS_ARB_ROUND_ROBIN_EN.
REQ-030 The priority pointer SHALL exist only when the macro is defined.
REQ-031 With CBUS_ARB_ROUND_ROBIN_EN defined: the winner is the first valid index searching pointer+1, pointer+2, ... modulo NUM_INPUTS.
REQ-032 Without the macro: fixed priority, lowest valid index wins; REQ-019 pointer update is omitted.

Verification
REQ-033 Reset, then ireqs[0].valid and ireqs[1].valid held, RR enabled -> grant_idx = 0 first, then 1, then 0; one IDLE cycle between grants.
REQ-034 Same stimulus, macro undefined -> grant_idx = 0 on every grant; input 1 starves.
REQ-035 4-beat burst on input 1 (ready on cycles 2,3,5,6, last on 6) -> beat_cnt reads 1,2,2,3,4; iresps[0] = 0 throughout; IDLE on cycle 7.
REQ-036 reset = 0 on beat 2 of a burst -> next cycle busy = 0, oreq = 0, beat_cnt = 0; next grant goes to input 0.
REQ-037 Owner drops valid before last -> busy stays 1 until oresp.last with ready.
REQ-038 NUM_INPUTS = 3, BEAT_W = 2, 5-beat burst -> beat_cnt saturates at 3; release on last.
